// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_sync
//  Purpose  : Fully synchronous SPI responder. SPI_SCLK, CS and MOSI are
//             oversampled on clk, so SPI_SCLK never clocks any flop. Supports
//             CPOL/CPHA modes 0-3 and 8/16/24/32-bit frames, MSB first.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 system clock, f_clk >= 8 x f_SCLK
//    rst                 asynchronous active-high reset
//    SPI_SCLK, CS, MOSI  SPI pins from the master (CS active low)
//    MISO                slave-out data, default_val while not busy
//    tx_data   [31:0]    word to send, captured at frame start
//    tx_load             1-cycle pulse when tx_data is captured
//    rx_data   [31:0]    last correctly received word, right-aligned
//    rx_valid            1-cycle pulse when rx_data updates
//    rx_err              1-cycle pulse when a frame had the wrong bit count
//    busy                high while a frame is in progress
//    transaction_length  00=8, 01=16, 10=24, 11=32 bits
//    CPOL, CPHA          SPI mode
//    default_val         idle MISO level and tx fill bit
// ============================================================================
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [31:0] tx_data,
  output logic        tx_load,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic        busy,
  input  logic [1:0]  transaction_length,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        default_val
);

  // Cycles WAIT_HIGH lets the CS pipeline refill with post-reset pin samples
  // before trusting it, since the CS flops reset to the inactive level.
  localparam int       c_FLUSH   = SYNC_STAGES + 1;
  localparam logic [7:0] c_FLUSH_V = 8'(c_FLUSH);
  localparam logic [5:0] c_CNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers plus one delayed copy for edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_all_high;

  assign w_sclk_s      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s        = r_cs_sync[SYNC_STAGES-1];
  // MOSI goes through the same depth as SCLK, so at a detected SCLK edge
  // w_mosi_s is the data line as it was when the pin edge occurred.
  assign w_mosi_s      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise   =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall   = ~w_sclk_s &  r_sclk_d;
  assign w_cs_fall     = ~w_cs_s   &  r_cs_d;
  assign w_cs_rise     =  w_cs_s   & ~r_cs_d;
  assign w_cs_all_high = (&r_cs_sync) & r_cs_d;

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [7:0]  r_flush;
  logic        r_cpol;
  logic        r_cpha;
  logic [1:0]  r_len;
  logic [5:0]  r_cnt;
  logic [31:0] r_rx_shift;
  logic [31:0] r_tx_shift;
  logic        r_miso;
  logic        r_busy;
  logic        r_tx_load;
  logic        r_rx_valid;
  logic        r_rx_err;
  logic [31:0] r_rx_data;

  logic        w_sample;
  logic        w_shift;
  logic [5:0]  w_n;
  logic [31:0] w_tx_aligned;

  // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling SCLK.
  assign w_sample = (r_cpol ^ r_cpha) ? w_sclk_fall : w_sclk_rise;
  assign w_shift  = (r_cpol ^ r_cpha) ? w_sclk_rise : w_sclk_fall;
  assign w_n      = {1'b0, r_len, 3'b000} + 6'd8;

  // Frame bits moved to the top of the tx register; the vacated low bits are
  // preloaded with the fill level so MISO settles at default_val once the
  // frame's bits have all been shifted out.
  always_comb begin
    w_tx_aligned = tx_data;
    case (transaction_length)
      2'b00:   w_tx_aligned = {tx_data[7:0],  {24{default_val}}};
      2'b01:   w_tx_aligned = {tx_data[15:0], {16{default_val}}};
      2'b10:   w_tx_aligned = {tx_data[23:0], {8{default_val}}};
      default: w_tx_aligned = tx_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WAIT_HIGH;
      r_flush    <= 8'd0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_len      <= 2'b00;
      r_cnt      <= 6'd0;
      r_rx_shift <= 32'd0;
      r_tx_shift <= 32'd0;
      r_miso     <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_load  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_data  <= 32'd0;
    end else begin
      r_tx_load  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;

      case (r_state)
        ST_WAIT_HIGH: begin
          if (r_flush != c_FLUSH_V) begin
            r_flush <= r_flush + 8'd1;
          end else if (w_cs_all_high) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_busy     <= 1'b1;
            r_cpol     <= CPOL;
            r_cpha     <= CPHA;
            r_len      <= transaction_length;
            r_tx_load  <= 1'b1;
            r_cnt      <= 6'd0;
            r_rx_shift <= 32'd0;
            if (CPHA) begin
              // First shift edge will present bit N-1.
              r_miso     <= default_val;
              r_tx_shift <= w_tx_aligned;
            end else begin
              // Bit N-1 must be on the line before the first sample edge.
              r_miso     <= w_tx_aligned[31];
              r_tx_shift <= {w_tx_aligned[30:0], default_val};
            end
          end
        end

        ST_ACTIVE: begin
          // A CS rise wins over any coincident SCLK edge.
          if (w_cs_rise) begin
            r_state <= ST_DONE;
          end else begin
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[30:0], w_mosi_s};
              if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 6'd1;
              end
            end
            if (w_shift) begin
              r_miso     <= r_tx_shift[31];
              r_tx_shift <= {r_tx_shift[30:0], default_val};
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (r_cnt == w_n) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_err   <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_WAIT_HIGH;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MISO     = r_busy ? r_miso : default_val;
  assign busy     = r_busy;
  assign tx_load  = r_tx_load;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_sync
//  Purpose  : Self-checking bench for spi_slave_sync. A behavioural SPI
//             master drives directed frames; expected receive results are
//             queued per frame and a monitor compares them against every
//             rx_valid / rx_err pulse.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave_sync;

  localparam int HALF = 80;  // SCLK half period: f_clk = 16 x f_SCLK

  logic        clk = 1'b0;
  logic        rst;
  logic        SPI_SCLK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic [31:0] tx_data;
  logic        tx_load;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        busy;
  logic [1:0]  transaction_length;
  logic        CPOL;
  logic        CPHA;
  logic        default_val;

  int checks = 0;
  int errors = 0;
  int tx_load_cnt = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_slave_sync #(.SYNC_STAGES(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .SPI_SCLK           (SPI_SCLK),
    .CS                 (CS),
    .MOSI               (MOSI),
    .MISO               (MISO),
    .tx_data            (tx_data),
    .tx_load            (tx_load),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_err             (rx_err),
    .busy               (busy),
    .transaction_length (transaction_length),
    .CPOL               (CPOL),
    .CPHA               (CPHA),
    .default_val        (default_val)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rx_valid/rx_err pulse.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_valid) check("rx_valid_width", {31'd0, rx_valid}, 32'd0);
    prev_valid = (rx_valid === 1'b1);
    if (tx_load === 1'b1) tx_load_cnt++;
    if (rx_valid === 1'b1 || rx_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx: rx_valid=%0b rx_err=%0b rx_data=0x%08h, expected no pulse",
                 rx_valid, rx_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_err_flag",   {31'd0, rx_err},   {31'd0, e.err});
        check("rx_valid_flag", {31'd0, rx_valid}, {31'd0, ~e.err});
        check("rx_data",       rx_data,           e.data);
      end
    end
  end

  // Behavioural SPI master. Drives nbits SCLK cycles; reads MISO on the
  // slave's sample edge (leading edge for CPHA=0, trailing for CPHA=1).
  task automatic spi_frame(input logic cpol, input logic cpha, input logic [1:0] len,
                           input int nbits, input logic [31:0] mosi_word,
                           input logic [31:0] txw, input logic dv,
                           output logic [31:0] miso_word);
    @(negedge clk);
    CPOL = cpol; CPHA = cpha; transaction_length = len;
    tx_data = txw; default_val = dv;
    SPI_SCLK = cpol; MOSI = 1'b0; miso_word = 32'd0;
    #(HALF);
    if (!cpha) MOSI = mosi_word[nbits-1];
    CS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      #(HALF);
      SPI_SCLK = ~cpol;
      if (!cpha) miso_word = {miso_word[30:0], MISO};
      else       MOSI = mosi_word[nbits-1-i];
      #(HALF);
      SPI_SCLK = cpol;
      if (!cpha) begin
        if (i + 1 < nbits) MOSI = mosi_word[nbits-2-i];
      end else begin
        miso_word = {miso_word[30:0], MISO};
      end
    end
    #(HALF);
    CS = 1'b1;
    MOSI = 1'b0;
    #(HALF);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d receive results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_frame(input string name, input logic cpol, input logic cpha,
                          input logic [1:0] len, input int nbits,
                          input logic [31:0] mosi_word, input logic [31:0] txw,
                          input logic dv, input logic [31:0] exp_read,
                          input logic exp_err, input logic [31:0] exp_rx);
    logic [31:0] rd;
    int          ld0;
    exp_t        e;
    e.err = exp_err;
    e.data = exp_rx;
    exp_q.push_back(e);
    ld0 = tx_load_cnt;
    spi_frame(cpol, cpha, len, nbits, mosi_word, txw, dv, rd);
    check({name, "_master_read"}, rd, exp_read);
    drain(name);
    check({name, "_tx_load_count"}, tx_load_cnt, ld0 + 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int   ld0;
    logic busy_seen;

    rst = 1'b1; CS = 1'b1; SPI_SCLK = 1'b0; MOSI = 1'b0;
    tx_data = 32'd0; transaction_length = 2'b00;
    CPOL = 1'b0; CPHA = 1'b0; default_val = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check("reset_rx_data",  rx_data, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_err",   {31'd0, rx_err},   32'd0);
    check("reset_tx_load",  {31'd0, tx_load},  32'd0);
    check("reset_busy",     {31'd0, busy},     32'd0);
    check("reset_miso_dv1", {31'd0, MISO},     32'd1);
    default_val = 1'b0;
    #1;
    check("reset_miso_dv0", {31'd0, MISO},     32'd0);

    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    //        name     cpol cpha len nbits mosi          tx            dv  read          err  rx
    do_frame("mode0_8",  0, 0, 2'b00,  8, 32'h0000003C, 32'h000000A5, 0, 32'h000000A5, 0, 32'h0000003C);
    do_frame("mode3_32", 1, 1, 2'b11, 32, 32'h12345678, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'h12345678);
    do_frame("mode1_16", 0, 1, 2'b01, 16, 32'h0000A55A, 32'h0000C3C3, 0, 32'h0000C3C3, 0, 32'h0000A55A);
    do_frame("mode2_16", 1, 0, 2'b01, 16, 32'h0000A55A, 32'h0000C3C3, 0, 32'h0000C3C3, 0, 32'h0000A55A);
    // Early release: 5 bits of 0xA5 read back, rx_data keeps 0xA55A.
    do_frame("early5",   0, 0, 2'b00,  5, 32'h00000015, 32'h000000A5, 0, 32'h00000014, 1, 32'h0000A55A);
    do_frame("after_err",0, 0, 2'b00,  8, 32'h00000081, 32'h0000005A, 0, 32'h0000005A, 0, 32'h00000081);
    // Overlong frame: bits 9 and 10 read back as the fill level 1.
    do_frame("over10",   0, 0, 2'b00, 10, 32'h000002B5, 32'h0000005A, 1, 32'h0000016B, 1, 32'h00000081);

    // CS held low across reset release while SCLK toggles: no frame.
    @(negedge clk);
    default_val = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
    CS = 1'b0; SPI_SCLK = 1'b0;
    rst = 1'b1;
    ld0 = tx_load_cnt;
    busy_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          #(HALF);
          SPI_SCLK = ~SPI_SCLK;
          MOSI = ~MOSI;
        end
      end
      begin
        #200;
        rst = 1'b0;
        repeat (140) begin
          @(negedge clk);
          if (busy === 1'b1) busy_seen = 1'b1;
        end
      end
    join
    CS = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    check("rst_cs_low_busy",    {31'd0, busy_seen}, 32'd0);
    check("rst_cs_low_tx_load", tx_load_cnt, ld0);
    check("rst_cs_low_rx_data", rx_data, 32'd0);

    do_frame("post_rst_24", 0, 0, 2'b10, 24, 32'h00ABCDEF, 32'h00123456, 0, 32'h00123456, 0, 32'h00ABCDEF);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
